subinst_rr_scheduler: RTL and testbench

- Round-robin scheduler that shares one downstream resource among the five sub-instances of a generated hierarchy level.
- Each sub-instance raises a request and signals completion.
- The scheduler grants exactly one instance at a time, holds the grant until that instance reports done or a timeout expires, then rotates priority.
- It sits in the parent level alongside the five instances it serves.

---
 rtl/subinst_rr_scheduler.sv | 93 +++++++++
 tb/tb_subinst_rr_scheduler.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/subinst_rr_scheduler.sv
// Round-robin arbiter sharing one downstream resource among N_REQ sibling instances.
// A grant is held until the owner's done pulse or a hold timeout, then priority rotates past it.
module subinst_rr_scheduler #(
  parameter int N_REQ   = 5,
  parameter int IDX_W   = 3,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] grant,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic             busy,
  output logic             timeout_err
);
  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [IDX_W:0]   N_L     = (IDX_W+1)'(N_REQ);
  localparam logic [IDX_W-1:0] N_LAST  = IDX_W'(N_REQ-1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT-1);
  localparam logic [N_REQ-1:0] ONE     = N_REQ'(1);

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] next_ptr;
  logic [TO_W-1:0]  timer;
  logic [N_REQ-1:0] req_rot;
  logic [IDX_W:0]   win_off;
  logic [IDX_W:0]   win_sum;
  logic [IDX_W-1:0] win_idx;
  logic             win_found;
  logic             done_hit;

  // Rotate req so bit 0 is the current priority holder; the lowest set bit
  // of the rotated vector is the winner's offset from ptr.
  always_comb begin
    req_rot   = N_REQ'({req, req} >> ptr);
    win_found = |req_rot;
    win_off   = '0;
    for (int k = N_REQ-1; k >= 0; k--)
      if (req_rot[k]) win_off = (IDX_W+1)'(k);
    win_sum  = {1'b0, ptr} + win_off;
    win_idx  = IDX_W'((win_sum >= N_L) ? win_sum - N_L : win_sum);
    next_ptr = (grant_idx == N_LAST) ? '0 : grant_idx + IDX_W'(1);
    // grant is one-hot, so masking done with it honours only the owner's bit
    done_hit = |(done & grant);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      timer       <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && win_found) begin
            state       <= GRANT;
            grant       <= ONE << win_idx;
            grant_valid <= 1'b1;
            grant_idx   <= win_idx;
            busy        <= 1'b1;
            timer       <= '0;
          end
        end
        GRANT: begin
          // done takes precedence over a coincident timeout
          if (done_hit || timer == TO_LAST) begin
            state       <= IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            busy        <= 1'b0;
            ptr         <= next_ptr;
            timeout_err <= !done_hit;
          end else begin
            timer <= timer + TO_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_subinst_rr_scheduler.sv
// Bench for subinst_rr_scheduler: two instances (TIMEOUT 255 and 4) share stimulus and are
// compared each cycle against a behavioural model, plus directed checks per scenario.
module tb_subinst_rr_scheduler;
  logic       clk = 1'b0;
  logic       rst_n, en;
  logic [4:0] req, done;
  logic [4:0] g0, g1;
  logic       gv0, gv1, busy0, busy1, te0, te1;
  logic [2:0] idx0, idx1;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  subinst_rr_scheduler u_dut0 (
    .clk(clk), .rst_n(rst_n), .enable(en), .req(req), .done(done),
    .grant(g0), .grant_valid(gv0), .grant_idx(idx0), .busy(busy0), .timeout_err(te0));

  subinst_rr_scheduler #(.N_REQ(5), .IDX_W(3), .TIMEOUT(4), .TO_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .enable(en), .req(req), .done(done),
    .grant(g1), .grant_valid(gv1), .grant_idx(idx1), .busy(busy1), .timeout_err(te1));

  wire [10:0] obs0 = {g0, gv0, idx0, busy0, te0};
  wire [10:0] obs1 = {g1, gv1, idx1, busy1, te1};

  // Reference model: who holds the resource, how long, and whose turn is next.
  typedef struct { bit st; int idx; int ptr; int timer; bit terr; } mdl_t;
  mdl_t m0, m1;

  function automatic mdl_t mstep(mdl_t s, int to, logic rst, logic e, logic [4:0] rq, logic [4:0] dn);
    mdl_t n = s;
    n.terr = 1'b0;
    if (!rst) begin
      n.st = 1'b0; n.idx = 0; n.ptr = 0; n.timer = 0;
      return n;
    end
    if (!s.st) begin
      if (e && rq != 5'b0)
        for (int k = 0; k < 5; k++) begin
          int j = (s.ptr + k) % 5;
          if (rq[j]) begin n.st = 1'b1; n.idx = j; n.timer = 0; break; end
        end
    end else if (dn[s.idx]) begin
      n.st = 1'b0; n.ptr = (s.idx + 1) % 5;
    end else if (s.timer == to - 1) begin
      n.st = 1'b0; n.ptr = (s.idx + 1) % 5; n.terr = 1'b1;
    end else begin
      n.timer = s.timer + 1;
    end
    return n;
  endfunction

  function automatic logic [10:0] exp_vec(mdl_t s);
    logic [4:0] g;
    g = s.st ? 5'(1 << s.idx) : 5'b0;
    return {g, s.st, 3'(s.idx), s.st, s.terr};
  endfunction

  always @(posedge clk) begin
    m0 <= mstep(m0, 255, rst_n, en, req, done);
    m1 <= mstep(m1, 4, rst_n, en, req, done);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; req = '0; done = '0;
    step(); step();
    tests++;
    if ({obs0, obs1} !== 22'b0) begin
      fails++; $display("FAIL reset_outputs obs=%h exp=0", {obs0, obs1});
    end
    rst_n = 1'b1;
    step();
    tests++;
    if ({obs0, obs1} !== {exp_vec(m0), exp_vec(m1)}) begin
      fails++; $display("FAIL reset_model obs=%h exp=%h", {obs0, obs1}, {exp_vec(m0), exp_vec(m1)});
    end
  endtask

  task automatic test_basic();
    en = 1'b1; req = 5'b10100;
    for (int i = 0; i < 4; i++) begin
      done = (i == 1) ? 5'b00100 : (i == 3) ? 5'b10000 : 5'b0;
      if (i == 3) req = '0;
      step();
      tests++;
      if ({obs0, obs1} !== {exp_vec(m0), exp_vec(m1)}) begin
        fails++; $display("FAIL basic_model i=%0d obs=%h exp=%h", i, {obs0, obs1}, {exp_vec(m0), exp_vec(m1)});
      end
      tests++;
      case (i)
        0: if (g0 !== 5'b00100 || idx0 !== 3'd2) begin
             fails++; $display("FAIL basic_first grant=%b idx=%0d exp 00100/2", g0, idx0); end
        1: if (g0 !== 5'b0 || gv0 !== 1'b0) begin
             fails++; $display("FAIL basic_release grant=%b exp 00000", g0); end
        2: if (g0 !== 5'b10000 || idx0 !== 3'd4) begin
             fails++; $display("FAIL basic_next grant=%b idx=%0d exp 10000/4", g0, idx0); end
        default: if (g0 !== 5'b0) begin
             fails++; $display("FAIL basic_done4 grant=%b exp 00000", g0); end
      endcase
    end
    done = '0;
  endtask

  task automatic test_rotation();
    int seq[$];
    int hold = 0;
    logic [4:0] prev;
    int exp_seq[6];
    exp_seq = '{0, 1, 2, 3, 4, 0};
    req = 5'b11111; prev = g0;
    for (int c = 0; c < 60 && seq.size() < 6; c++) begin
      done = (hold == 2) ? g0 : 5'b0;
      step();
      tests++;
      if ({obs0, obs1} !== {exp_vec(m0), exp_vec(m1)}) begin
        fails++; $display("FAIL rot_model c=%0d obs=%h exp=%h", c, {obs0, obs1}, {exp_vec(m0), exp_vec(m1)});
      end
      if (g0 != 5'b0 && prev == 5'b0) seq.push_back(int'(idx0));
      tests++;
      if (g0 != 5'b0 && prev != 5'b0 && g0 != prev) begin
        fails++; $display("FAIL rot_spacing prev=%b grant=%b exp idle gap", prev, g0);
      end
      hold = (g0 != 5'b0) ? hold + 1 : 0;
      prev = g0;
    end
    tests++;
    if (seq.size() != 6) begin
      fails++; $display("FAIL rot_count got=%0d exp=6", seq.size());
    end
    for (int i = 0; i < seq.size() && i < 6; i++) begin
      tests++;
      if (seq[i] != exp_seq[i]) begin
        fails++; $display("FAIL rot_order pos=%0d got=%0d exp=%0d", i, seq[i], exp_seq[i]);
      end
    end
    req = '0; done = 5'b11111;
    step();
    done = '0;
  endtask

  task automatic test_timeout();
    logic [4:0] eg [6];
    logic       et [6];
    eg = '{5'b00010, 5'b00010, 5'b00010, 5'b00010, 5'b00000, 5'b00010};
    et = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    req = 5'b00010;
    for (int i = 0; i < 6; i++) begin
      step();
      tests++;
      if ({obs0, obs1} !== {exp_vec(m0), exp_vec(m1)}) begin
        fails++; $display("FAIL to_model i=%0d obs=%h exp=%h", i, {obs0, obs1}, {exp_vec(m0), exp_vec(m1)});
      end
      tests++;
      if (g1 !== eg[i] || te1 !== et[i]) begin
        fails++; $display("FAIL to_seq i=%0d grant=%b terr=%b exp %b/%b", i, g1, te1, eg[i], et[i]);
      end
    end
    rst_n = 1'b0; req = '0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_ignore_done();
    req = 5'b01000;
    for (int i = 0; i < 5; i++) begin
      done = (i >= 1 && i <= 3) ? 5'b10001 : (i == 4) ? 5'b01000 : 5'b0;
      if (i == 4) req = '0;
      step();
      tests++;
      if ({obs0, obs1} !== {exp_vec(m0), exp_vec(m1)}) begin
        fails++; $display("FAIL ign_model i=%0d obs=%h exp=%h", i, {obs0, obs1}, {exp_vec(m0), exp_vec(m1)});
      end
      tests++;
      if (i < 4 && (g0 !== 5'b01000 || g1 !== 5'b01000)) begin
        fails++; $display("FAIL ign_hold i=%0d grant0=%b grant1=%b exp 01000", i, g0, g1);
      end else if (i == 4 && (g1 !== 5'b0 || te1 !== 1'b0 || g0 !== 5'b0)) begin
        fails++; $display("FAIL ign_coincide grant1=%b terr1=%b exp 00000/0", g1, te1);
      end
    end
    done = '0;
  endtask

  task automatic test_enable();
    en = 1'b1; req = 5'b00100;
    for (int i = 0; i < 7; i++) begin
      done = (i == 3) ? 5'b00100 : (i == 6) ? 5'b00001 : 5'b0;
      step();
      tests++;
      if ({obs0, obs1} !== {exp_vec(m0), exp_vec(m1)}) begin
        fails++; $display("FAIL en_model i=%0d obs=%h exp=%h", i, {obs0, obs1}, {exp_vec(m0), exp_vec(m1)});
      end
      tests++;
      case (i)
        0, 1, 2: if (g0 !== 5'b00100 || idx0 !== 3'd2) begin
             fails++; $display("FAIL en_hold i=%0d grant=%b exp 00100", i, g0); end
        3, 4: if (g0 !== 5'b0) begin
             fails++; $display("FAIL en_blocked i=%0d grant=%b exp 00000", i, g0); end
        5: if (g0 !== 5'b00001 || idx0 !== 3'd0) begin
             fails++; $display("FAIL en_resume grant=%b idx=%0d exp 00001/0", g0, idx0); end
        default: if (g0 !== 5'b0) begin
             fails++; $display("FAIL en_release grant=%b exp 00000", g0); end
      endcase
      if (i == 0) begin en = 1'b0; req = 5'b00001; end
      if (i == 4) en = 1'b1;
      if (i == 5) req = '0;
    end
    done = '0;
  endtask

  task automatic test_reset_mid();
    req = 5'b01000;
    step();
    tests++;
    if (g0 !== 5'b01000) begin
      fails++; $display("FAIL rstmid_grant grant=%b exp 01000", g0);
    end
    for (int i = 0; i < 10; i++) step();
    rst_n = 1'b0; req = 5'b11000;
    step();
    tests++;
    if ({obs0, obs1} !== 22'b0) begin
      fails++; $display("FAIL rstmid_clear obs=%h exp=0", {obs0, obs1});
    end
    rst_n = 1'b1;
    step();
    tests++;
    if (g0 !== 5'b01000 || idx0 !== 3'd3 || {obs0, obs1} !== {exp_vec(m0), exp_vec(m1)}) begin
      fails++; $display("FAIL rstmid_regrant grant=%b idx=%0d exp 01000/3", g0, idx0);
    end
    req = '0; done = 5'b01000;
    step();
    done = '0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      en    = ($urandom_range(0, 9) != 0);
      req   = 5'($urandom);
      done  = ($urandom_range(0, 3) == 0) ? (g0 | 5'($urandom)) : 5'($urandom) & 5'($urandom) & 5'($urandom);
      step();
      tests++;
      if ({obs0, obs1} !== {exp_vec(m0), exp_vec(m1)}) begin
        fails++; $display("FAIL rand_model c=%0d obs=%h exp=%h", c, {obs0, obs1}, {exp_vec(m0), exp_vec(m1)});
      end
      tests++;
      if (!$onehot0(g1) || gv1 !== |g1 || busy1 !== gv1) begin
        fails++; $display("FAIL rand_invariant c=%0d grant=%b valid=%b busy=%b", c, g1, gv1, busy1);
      end
    end
    rst_n = 1'b1; req = '0; done = '0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; req = '0; done = '0;
    test_reset();
    test_basic();
    test_rotation();
    test_timeout();
    test_ignore_done();
    test_enable();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
